// File: rtl/bs_pkg.sv
// Shared types for the binary search block: FSM state encoding and the
// hex-to-7-segment decode used to display the result index.
package bs_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FETCH   = 2'd1,
    COMPARE = 2'd2,
    DONE    = 2'd3
  } state_t;

  // Active-high segments, bit order {g,f,e,d,c,b,a}.
  function automatic logic [6:0] seg7_encode(input logic [3:0] digit);
    logic [6:0] s;
    case (digit)
      4'h0: s = 7'h3F;
      4'h1: s = 7'h06;
      4'h2: s = 7'h5B;
      4'h3: s = 7'h4F;
      4'h4: s = 7'h66;
      4'h5: s = 7'h6D;
      4'h6: s = 7'h7D;
      4'h7: s = 7'h07;
      4'h8: s = 7'h7F;
      4'h9: s = 7'h6F;
      4'hA: s = 7'h77;
      4'hB: s = 7'h7C;
      4'hC: s = 7'h39;
      4'hD: s = 7'h5E;
      4'hE: s = 7'h79;
      default: s = 7'h71;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/binary_search_param_seg7.sv
// One hex digit of 7-segment display, decoded combinationally.
module binary_search_param_seg7
  import bs_pkg::*;
(
  input  logic [3:0] digit,
  output logic [6:0] seg
);

  assign seg = seg7_encode(digit);

endmodule

// File: rtl/binary_search_param.sv
// Binary search over an external sorted synchronous RAM (1-cycle read latency).
// Each probe costs two cycles: FETCH drives the address, COMPARE sees the data.
module binary_search_param
  import bs_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int ADDR_W     = 5,
  parameter bit DESCENDING = 1'b0,
  parameter int PCNT_W     = $clog2(ADDR_W + 2),
  parameter int NDIG       = (ADDR_W + 4) / 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [DATA_W-1:0]   A,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic                mem_rd,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                found,
  output logic                notfound,
  output logic [ADDR_W:0]     L,
  output logic [PCNT_W-1:0]   probes,
  output logic [7*NDIG-1:0]   seg,
  output state_t              state
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W:0] TOP = (ADDR_W + 1)'(DEPTH - 1);

  logic [DATA_W-1:0] key;
  logic [ADDR_W:0]   lo;
  logic [ADDR_W:0]   hi;
  logic [ADDR_W:0]   mid;
  logic              is_equal;
  logic              is_before;
  logic [4*NDIG-1:0] l_pad;

  // Midpoint written as lo + half-span so the sum can never overflow.
  function automatic logic [ADDR_W-1:0] mid_of(input logic [ADDR_W:0] l,
                                               input logic [ADDR_W:0] h);
    return ADDR_W'(l + ((h - l) >> 1));
  endfunction

  always_comb begin
    mid       = lo + ((hi - lo) >> 1);
    is_equal  = (key == mem_rdata);
    is_before = DESCENDING ? (key > mem_rdata) : (key < mem_rdata);
  end

  // mem_addr/mem_rd are registered: the next probe address is prepared on the
  // edge that enters FETCH, so the RAM samples it on the edge leaving FETCH.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      key      <= '0;
      lo       <= '0;
      hi       <= '0;
      mem_addr <= '0;
      mem_rd   <= 1'b0;
      found    <= 1'b0;
      notfound <= 1'b0;
      L        <= '0;
      probes   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            key      <= A;
            lo       <= '0;
            hi       <= TOP;
            probes   <= '0;
            mem_addr <= mid_of('0, TOP);
            mem_rd   <= 1'b1;
            state    <= FETCH;
          end
        end
        FETCH: begin
          mem_rd <= 1'b0;
          probes <= probes + 1'b1;
          state  <= COMPARE;
        end
        COMPARE: begin
          if (is_equal) begin
            found <= 1'b1;
            L     <= mid;
            state <= DONE;
          end else if (is_before) begin
            if (mid == lo) begin
              notfound <= 1'b1;
              L        <= lo;
              state    <= DONE;
            end else begin
              hi       <= mid - 1'b1;
              mem_addr <= mid_of(lo, mid - 1'b1);
              mem_rd   <= 1'b1;
              state    <= FETCH;
            end
          end else begin
            if (mid == hi) begin
              notfound <= 1'b1;
              L        <= mid + 1'b1;
              state    <= DONE;
            end else begin
              lo       <= mid + 1'b1;
              mem_addr <= mid_of(mid + 1'b1, hi);
              mem_rd   <= 1'b1;
              state    <= FETCH;
            end
          end
        end
        DONE: begin
          if (!start) begin
            found    <= 1'b0;
            notfound <= 1'b0;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    l_pad           = '0;
    l_pad[ADDR_W:0] = L;
  end

  for (genvar g = 0; g < NDIG; g++) begin : g_dig
    binary_search_param_seg7 u_seg7 (
      .digit (l_pad[4*g +: 4]),
      .seg   (seg[7*g +: 7])
    );
  end

endmodule

// File: tb/tb_binary_search_param.sv
// Directed bench for binary_search_param: ascending and descending RAM models,
// hand-computed results, latency, hold/clear behaviour and reset abort.
module tb_binary_search_param;
  import bs_pkg::*;

  localparam int DW = 8;
  localparam int AW = 5;
  localparam int PW = 3;
  localparam int ND = 2;

  logic          clk, reset;
  logic          start, start_d;
  logic [DW-1:0] a, a_d;
  logic [AW-1:0] mem_addr, mem_addr_d;
  logic          mem_rd, mem_rd_d;
  logic [DW-1:0] mem_rdata, mem_rdata_d;
  logic          found, notfound, found_d, notfound_d;
  logic [AW:0]   l, l_d;
  logic [PW-1:0] probes, probes_d;
  logic [7*ND-1:0] seg, seg_d;
  state_t        state, state_d;

  logic [DW-1:0] mem_asc [32];
  logic [DW-1:0] mem_desc[32];

  int n_assert = 0;
  int n_fail   = 0;
  int lat, rds;

  binary_search_param #(.DATA_W(DW), .ADDR_W(AW), .DESCENDING(1'b0)) dut (
    .clk(clk), .reset(reset), .start(start), .A(a),
    .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_rdata(mem_rdata),
    .found(found), .notfound(notfound), .L(l), .probes(probes),
    .seg(seg), .state(state)
  );

  binary_search_param #(.DATA_W(DW), .ADDR_W(AW), .DESCENDING(1'b1)) dut_d (
    .clk(clk), .reset(reset), .start(start_d), .A(a_d),
    .mem_addr(mem_addr_d), .mem_rd(mem_rd_d), .mem_rdata(mem_rdata_d),
    .found(found_d), .notfound(notfound_d), .L(l_d), .probes(probes_d),
    .seg(seg_d), .state(state_d)
  );

  // Clock and RAM models
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    for (int i = 0; i < 32; i++) begin
      mem_asc[i]  = 8'(2 * i);
      mem_desc[i] = 8'(62 - 2 * i);
    end
  end

  always @(posedge clk) begin
    mem_rdata   <= mem_asc[mem_addr];
    mem_rdata_d <= mem_desc[mem_addr_d];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Waits for a result; o_lat = edges after the one that sampled start.
  task automatic wait_done(input bit desc, output int o_lat, output int o_rds);
    o_lat = -1;
    o_rds = 0;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk);
      #1;
      if (desc ? mem_rd_d : mem_rd) o_rds++;
      if (desc ? (found_d || notfound_d) : (found || notfound)) begin
        o_lat = i;
        break;
      end
    end
    check("exclusive", desc ? (found_d & notfound_d) : (found & notfound), 0);
  endtask

  task automatic search(input bit desc, input logic [DW-1:0] key,
                        output int o_lat, output int o_rds);
    @(negedge clk);
    if (desc) begin a_d = key; start_d = 1'b1; end
    else      begin a   = key; start   = 1'b1; end
    wait_done(desc, o_lat, o_rds);
  endtask

  task automatic release_start(input bit desc, input logic [31:0] exp_l,
                               input logic [31:0] exp_p);
    @(negedge clk);
    if (desc) start_d = 1'b0; else start = 1'b0;
    @(posedge clk);
    #1;
    check("clear_found", desc ? found_d : found, 0);
    check("clear_notfound", desc ? notfound_d : notfound, 0);
    check("hold_L", desc ? l_d : l, exp_l);
    check("hold_probes", desc ? probes_d : probes, exp_p);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; start_d = 1'b0; a = '0; a_d = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_found", found, 0);
    check("rst_notfound", notfound, 0);
    check("rst_L", l, 0);
    check("rst_probes", probes, 0);
    check("rst_mem_rd", mem_rd, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_state", state, IDLE);
    @(negedge clk);
    reset = 1'b0;

    // Key in the middle: one probe, result two edges after start
    search(1'b0, 8'd30, lat, rds);
    check("k30_found", found, 1);
    check("k30_L", l, 15);
    check("k30_probes", probes, 1);
    check("k30_latency", lat, 2);
    check("k30_reads", rds, 1);
    check("k30_seg", seg, {7'h3F, 7'h71});
    repeat (2) @(posedge clk);
    #1;
    check("k30_hold_found", found, 1);
    check("k30_hold_state", state, DONE);
    release_start(1'b0, 15, 1);

    search(1'b0, 8'd0, lat, rds);
    check("k0_found", found, 1);
    check("k0_L", l, 0);
    check("k0_probes", probes, 5);
    check("k0_latency", lat, 10);
    check("k0_reads", rds, 5);
    release_start(1'b0, 0, 5);

    search(1'b0, 8'd62, lat, rds);
    check("k62_found", found, 1);
    check("k62_L", l, 31);
    check("k62_probes", probes, 6);
    check("k62_latency", lat, 12);
    release_start(1'b0, 31, 6);

    search(1'b0, 8'd3, lat, rds);
    check("k3_notfound", notfound, 1);
    check("k3_found", found, 0);
    check("k3_L", l, 2);
    check("k3_probes", probes, 5);
    check("k3_latency", lat, 10);
    release_start(1'b0, 2, 5);

    search(1'b0, 8'd255, lat, rds);
    check("k255_notfound", notfound, 1);
    check("k255_L", l, 32);
    check("k255_probes", probes, 6);
    check("k255_seg", seg, {7'h5B, 7'h3F});
    release_start(1'b0, 32, 6);

    // start dropped and key changed mid-search: result unaffected, pulse of one cycle
    @(negedge clk);
    a = 8'd62; start = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    start = 1'b0; a = 8'd0;
    wait_done(1'b0, lat, rds);
    check("drop_found", found, 1);
    check("drop_L", l, 31);
    check("drop_probes", probes, 6);
    @(posedge clk);
    #1;
    check("drop_pulse", found, 0);
    check("drop_state", state, IDLE);

    // Reset during the third COMPARE of key 0, start left high
    @(negedge clk);
    a = 8'd0; start = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    check("abort_in_compare", state, COMPARE);
    #2;
    reset = 1'b1;
    #1;
    check("abort_found", found, 0);
    check("abort_notfound", notfound, 0);
    check("abort_L", l, 0);
    check("abort_probes", probes, 0);
    check("abort_mem_rd", mem_rd, 0);
    check("abort_mem_addr", mem_addr, 0);
    check("abort_state", state, IDLE);
    @(negedge clk);
    reset = 1'b0;
    wait_done(1'b0, lat, rds);
    check("post_rst_found", found, 1);
    check("post_rst_L", l, 0);
    check("post_rst_probes", probes, 5);
    check("post_rst_latency", lat, 10);
    release_start(1'b0, 0, 5);

    // Descending RAM
    search(1'b1, 8'd62, lat, rds);
    check("d62_found", found_d, 1);
    check("d62_L", l_d, 0);
    check("d62_probes", probes_d, 5);
    release_start(1'b1, 0, 5);

    search(1'b1, 8'd1, lat, rds);
    check("d1_notfound", notfound_d, 1);
    check("d1_L", l_d, 31);
    check("d1_probes", probes_d, 6);
    check("d1_latency", lat, 12);
    release_start(1'b1, 31, 6);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
